// File: rtl/wf_ready_tracker_pkg.sv
// Shared definitions for the wavefront readiness scoreboard.
// Holds the slot count, id width and the per-slot state encoding.
package wf_ready_tracker_pkg;

  localparam int unsigned NUM_WF  = 40;
  localparam int unsigned WF_ID_W = 6;

  typedef enum logic [1:0] {
    SlotFree      = 2'd0,
    SlotWaitInstr = 2'd1,
    SlotReady     = 2'd2,
    SlotInflight  = 2'd3
  } slot_state_e;

endpackage

// File: rtl/wf_ready_tracker_slot_fsm.sv
// One wavefront slot's lifecycle FSM: FREE -> WAIT_INSTR -> READY -> INFLIGHT.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   dispatch_hit   slot allocated this cycle
//   instr_hit      next instruction available this cycle
//   issue_hit      slot issued this cycle
//   retire_hit     in-flight instruction retired this cycle
//   retire_end     retiring instruction was s_endpgm
//   ready          slot is READY (decoded from the state flops)
//   busy_next      slot will be non-FREE after this edge
//   done           end-retire accepted this cycle
//   illegal        at least one event does not fit the current state
module wf_slot_fsm
  import wf_ready_tracker_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic dispatch_hit,
  input  logic instr_hit,
  input  logic issue_hit,
  input  logic retire_hit,
  input  logic retire_end,
  output logic ready,
  output logic busy_next,
  output logic done,
  output logic illegal
);

  slot_state_e state_q, state_d;

  // Legal events move the slot; any event that does not fit the current
  // state is flagged and otherwise has no effect.
  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      SlotFree: begin
        if (dispatch_hit) state_d = SlotWaitInstr;
        illegal = instr_hit | issue_hit | retire_hit;
      end
      SlotWaitInstr: begin
        if (instr_hit) state_d = SlotReady;
        illegal = dispatch_hit | issue_hit | retire_hit;
      end
      SlotReady: begin
        if (issue_hit) state_d = SlotInflight;
        illegal = dispatch_hit | instr_hit | retire_hit;
      end
      SlotInflight: begin
        if (retire_hit && retire_end) begin
          state_d = SlotFree;
          done    = 1'b1;
          illegal = dispatch_hit | issue_hit | instr_hit;
        end else if (retire_hit) begin
          // A same-cycle instruction arrival skips WAIT_INSTR.
          state_d = instr_hit ? SlotReady : SlotWaitInstr;
          illegal = dispatch_hit | issue_hit;
        end else begin
          illegal = dispatch_hit | issue_hit | instr_hit;
        end
      end
      default: state_d = SlotFree;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SlotFree;
    end else begin
      state_q <= state_d;
    end
  end

  assign ready     = (state_q == SlotReady);
  assign busy_next = (state_d != SlotFree);

endmodule

// File: rtl/wf_ready_tracker.sv
// Per-wavefront readiness scoreboard feeding the issue arbiter.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   wf_dispatch_en/_id              wavefront allocated to a slot
//   instr_valid_en/_wf_id           next instruction buffered for a slot
//   issued_en/issued_wf_id          arbiter issued a slot
//   retire_en/_wf_id/_is_end        in-flight instruction retired
//   wf_ready_arry                   bit i set while slot i is READY
//   wf_done_en/wf_done_id           one-cycle pulse on wavefront completion
//   active_count                    registered count of non-FREE slots
//   protocol_err                    sticky illegal-event flag
module wf_ready_tracker #(
  parameter int unsigned NUM_WF  = wf_ready_tracker_pkg::NUM_WF,
  parameter int unsigned WF_ID_W = wf_ready_tracker_pkg::WF_ID_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wf_dispatch_en,
  input  logic [WF_ID_W-1:0] wf_dispatch_id,
  input  logic               instr_valid_en,
  input  logic [WF_ID_W-1:0] instr_valid_wf_id,
  input  logic               issued_en,
  input  logic [WF_ID_W-1:0] issued_wf_id,
  input  logic               retire_en,
  input  logic [WF_ID_W-1:0] retire_wf_id,
  input  logic               retire_is_end,
  output logic [NUM_WF-1:0]  wf_ready_arry,
  output logic               wf_done_en,
  output logic [WF_ID_W-1:0] wf_done_id,
  output logic [WF_ID_W-1:0] active_count,
  output logic               protocol_err
);

  import wf_ready_tracker_pkg::*;

  localparam logic [WF_ID_W-1:0] IdLimit = WF_ID_W'(NUM_WF);

  logic [NUM_WF-1:0]  dispatch_hit, instr_hit, issue_hit, retire_hit;
  logic [NUM_WF-1:0]  slot_busy_next, slot_done, slot_illegal;
  logic               range_err;
  logic [WF_ID_W-1:0] count_d;

  // Out-of-range ids never match a slot, so they fall out of the decode.
  always_comb begin
    dispatch_hit = '0;
    instr_hit    = '0;
    issue_hit    = '0;
    retire_hit   = '0;
    for (int unsigned i = 0; i < NUM_WF; i++) begin
      dispatch_hit[i] = wf_dispatch_en && (wf_dispatch_id == WF_ID_W'(i));
      instr_hit[i]    = instr_valid_en && (instr_valid_wf_id == WF_ID_W'(i));
      issue_hit[i]    = issued_en && (issued_wf_id == WF_ID_W'(i));
      retire_hit[i]   = retire_en && (retire_wf_id == WF_ID_W'(i));
    end
    range_err = (wf_dispatch_en && (wf_dispatch_id >= IdLimit)) ||
                (instr_valid_en && (instr_valid_wf_id >= IdLimit)) ||
                (issued_en && (issued_wf_id >= IdLimit)) ||
                (retire_en && (retire_wf_id >= IdLimit));
  end

  for (genvar g = 0; g < NUM_WF; g++) begin : gen_slot
    wf_slot_fsm u_slot (
      .clk          (clk),
      .rst          (rst),
      .dispatch_hit (dispatch_hit[g]),
      .instr_hit    (instr_hit[g]),
      .issue_hit    (issue_hit[g]),
      .retire_hit   (retire_hit[g]),
      .retire_end   (retire_is_end),
      .ready        (wf_ready_arry[g]),
      .busy_next    (slot_busy_next[g]),
      .done         (slot_done[g]),
      .illegal      (slot_illegal[g])
    );
  end

  // Count next-state occupancy so the register matches the slots it tracks.
  always_comb begin
    count_d = '0;
    for (int unsigned i = 0; i < NUM_WF; i++) begin
      count_d = count_d + WF_ID_W'(slot_busy_next[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_count <= '0;
      wf_done_en   <= 1'b0;
      wf_done_id   <= '0;
      protocol_err <= 1'b0;
    end else begin
      active_count <= count_d;
      wf_done_en   <= |slot_done;
      if (|slot_done) wf_done_id <= retire_wf_id;
      protocol_err <= protocol_err | (|slot_illegal) | range_err;
    end
  end

endmodule

// File: tb/tb_wf_ready_tracker.sv
module tb_wf_ready_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wf_dispatch_en = 1'b0;
  logic [5:0]  wf_dispatch_id = '0;
  logic        instr_valid_en = 1'b0;
  logic [5:0]  instr_valid_wf_id = '0;
  logic        issued_en = 1'b0;
  logic [5:0]  issued_wf_id = '0;
  logic        retire_en = 1'b0;
  logic [5:0]  retire_wf_id = '0;
  logic        retire_is_end = 1'b0;
  logic [39:0] wf_ready_arry;
  logic        wf_done_en;
  logic [5:0]  wf_done_id;
  logic [5:0]  active_count;
  logic        protocol_err;

  wf_ready_tracker dut (
    .clk               (clk),
    .rst               (rst),
    .wf_dispatch_en    (wf_dispatch_en),
    .wf_dispatch_id    (wf_dispatch_id),
    .instr_valid_en    (instr_valid_en),
    .instr_valid_wf_id (instr_valid_wf_id),
    .issued_en         (issued_en),
    .issued_wf_id      (issued_wf_id),
    .retire_en         (retire_en),
    .retire_wf_id      (retire_wf_id),
    .retire_is_end     (retire_is_end),
    .wf_ready_arry     (wf_ready_arry),
    .wf_done_en        (wf_done_en),
    .wf_done_id        (wf_done_id),
    .active_count      (active_count),
    .protocol_err      (protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [39:0] rdy;
    logic        den;
    logic [5:0]  did;
    logic [5:0]  cnt;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check_out(input exp_t e);
    logic ok;
    vectors++;
    ok = (wf_ready_arry === e.rdy) && (wf_done_en === e.den) &&
         (!e.den || (wf_done_id === e.did)) && (active_count === e.cnt) &&
         (protocol_err === e.err);
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got ready=%h done=%b/%0d count=%0d err=%b, want ready=%h done=%b/%0d count=%0d err=%b",
               e.name, wf_ready_arry, wf_done_en, wf_done_id, active_count, protocol_err,
               e.rdy, e.den, e.did, e.cnt, e.err);
    end
  endtask

  // Each clock edge is an output presentation; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_out(e);
      end
    end
  end

  task automatic drive(input logic de, input logic [5:0] did, input logic ie,
                       input logic [5:0] iid, input logic se, input logic [5:0] sid,
                       input logic re, input logic [5:0] rid, input logic rend);
    wf_dispatch_en = de;  wf_dispatch_id = did;
    instr_valid_en = ie;  instr_valid_wf_id = iid;
    issued_en = se;       issued_wf_id = sid;
    retire_en = re;       retire_wf_id = rid;
    retire_is_end = rend;
  endtask

  task automatic idle();
    drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
  endtask

  function automatic exp_t mk(input string name, input logic [39:0] rdy, input logic den,
                              input logic [5:0] did, input logic [5:0] cnt, input logic err);
    exp_t e;
    e.name = name; e.rdy = rdy; e.den = den; e.did = did; e.cnt = cnt; e.err = err;
    return e;
  endfunction

  // Push the expectation for the state after the coming edge, then advance.
  task automatic expect_next(input string name, input logic [39:0] rdy, input logic den,
                             input logic [5:0] did, input logic [5:0] cnt, input logic err);
    sb.push_back(mk(name, rdy, den, did, cnt, err));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    idle();
    #3;
    check_out(mk("reset_state", 40'h0, 1'b0, 6'd0, 6'd0, 1'b0));
    @(negedge clk);
    rst = 1'b0;

    // Basic lifecycle on slot 5.
    drive(1, 6'd5, 0, 6'd0, 0, 6'd0, 0, 6'd0, 0);
    expect_next("dispatch5", 40'h0, 0, 6'd0, 6'd1, 0);
    drive(0, 6'd0, 1, 6'd5, 0, 6'd0, 0, 6'd0, 0);
    expect_next("instr5", 40'h20, 0, 6'd0, 6'd1, 0);
    drive(0, 6'd0, 0, 6'd0, 1, 6'd5, 0, 6'd0, 0);
    expect_next("issue5", 40'h0, 0, 6'd0, 6'd1, 0);
    drive(0, 6'd0, 1, 6'd5, 0, 6'd0, 1, 6'd5, 0);
    expect_next("retire5_instr5", 40'h20, 0, 6'd0, 6'd1, 0);
    drive(0, 6'd0, 0, 6'd0, 1, 6'd5, 0, 6'd0, 0);
    expect_next("issue5_again", 40'h0, 0, 6'd0, 6'd1, 0);
    drive(0, 6'd0, 0, 6'd0, 0, 6'd0, 1, 6'd5, 1);
    expect_next("retire5_end", 40'h0, 1, 6'd5, 6'd0, 0);
    idle();
    expect_next("done_pulse_ends", 40'h0, 0, 6'd0, 6'd0, 0);

    // Concurrent events on distinct slots.
    drive(1, 6'd7, 0, 6'd0, 0, 6'd0, 0, 6'd0, 0);
    expect_next("dispatch7", 40'h0, 0, 6'd0, 6'd1, 0);
    drive(1, 6'd8, 1, 6'd7, 0, 6'd0, 0, 6'd0, 0);
    expect_next("dispatch8_instr7", 40'h80, 0, 6'd0, 6'd2, 0);
    drive(1, 6'd9, 1, 6'd8, 1, 6'd7, 0, 6'd0, 0);
    expect_next("dispatch9_instr8_issue7", 40'h100, 0, 6'd0, 6'd3, 0);
    drive(1, 6'd10, 0, 6'd0, 0, 6'd0, 1, 6'd7, 1);
    expect_next("dispatch10_end7", 40'h100, 1, 6'd7, 6'd3, 0);

    // Fill every remaining slot.
    k = 3;
    for (int i = 0; i < 40; i++) begin
      if (i != 8 && i != 9 && i != 10) begin
        drive(1, 6'(i), 0, 6'd0, 0, 6'd0, 0, 6'd0, 0);
        k++;
        expect_next($sformatf("fill%0d", i), 40'h100, 0, 6'd0, 6'(k), 0);
      end
    end
    drive(1, 6'd12, 0, 6'd0, 0, 6'd0, 0, 6'd0, 0);
    expect_next("redispatch12", 40'h100, 0, 6'd0, 6'd40, 1);
    drive(0, 6'd0, 0, 6'd0, 1, 6'd45, 0, 6'd0, 0);
    expect_next("issue45_sticky", 40'h100, 0, 6'd0, 6'd40, 1);

    idle();
    rst = 1'b1;
    #1;
    check_out(mk("reset_clears_full", 40'h0, 1'b0, 6'd0, 6'd0, 1'b0));
    @(negedge clk);
    rst = 1'b0;

    // Out-of-range id on a clean error flag.
    drive(1, 6'd0, 0, 6'd0, 0, 6'd0, 0, 6'd0, 0);
    expect_next("dispatch0", 40'h0, 0, 6'd0, 6'd1, 0);
    drive(1, 6'd39, 1, 6'd0, 0, 6'd0, 0, 6'd0, 0);
    expect_next("dispatch39_instr0", 40'h1, 0, 6'd0, 6'd2, 0);
    drive(0, 6'd0, 1, 6'd39, 0, 6'd0, 0, 6'd0, 0);
    expect_next("instr39", 40'h80_0000_0001, 0, 6'd0, 6'd2, 0);
    drive(0, 6'd0, 0, 6'd0, 1, 6'd45, 0, 6'd0, 0);
    expect_next("issue45", 40'h80_0000_0001, 0, 6'd0, 6'd2, 1);
    drive(0, 6'd0, 0, 6'd0, 1, 6'd0, 0, 6'd0, 0);
    expect_next("issue0", 40'h80_0000_0000, 0, 6'd0, 6'd2, 1);

    // Reset lands mid-cycle while an end-retire is pending.
    drive(0, 6'd0, 0, 6'd0, 0, 6'd0, 1, 6'd0, 1);
    #2;
    rst = 1'b1;
    #1;
    check_out(mk("async_reset_immediate", 40'h0, 1'b0, 6'd0, 6'd0, 1'b0));
    expect_next("reset_no_done", 40'h0, 0, 6'd0, 6'd0, 0);
    idle();
    rst = 1'b0;
    expect_next("after_reset_idle", 40'h0, 0, 6'd0, 6'd0, 0);

    // Instruction arrival for a FREE slot is illegal.
    drive(1, 6'd3, 0, 6'd0, 0, 6'd0, 0, 6'd0, 0);
    expect_next("dispatch3", 40'h0, 0, 6'd0, 6'd1, 0);
    drive(0, 6'd0, 1, 6'd4, 0, 6'd0, 0, 6'd0, 0);
    expect_next("instr4_free", 40'h0, 0, 6'd0, 6'd1, 1);
    drive(0, 6'd0, 1, 6'd3, 0, 6'd0, 0, 6'd0, 0);
    expect_next("instr3", 40'h8, 0, 6'd0, 6'd1, 1);
    idle();

    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wf_ready_tracker.md
# wf_ready_tracker

Per-wavefront readiness scoreboard directly upstream of the issue-stage round-robin arbiter. Tracks each of 40 wavefront slots through dispatch, instruction arrival, issue and retirement, and drives the 40-bit ready vector the arbiter selects from. Also reports wavefront completion and live slot occupancy to the dispatcher.

## Interface
Parameters:
- NUM_WF, 40, number of wavefront slots
- WF_ID_W, 6, wavefront id width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- wf_dispatch_en  in  1  new wavefront allocated to slot wf_dispatch_id
- wf_dispatch_id  in  6  slot id
- instr_valid_en  in  1  instruction buffer now holds next instruction for instr_valid_wf_id
- instr_valid_wf_id  in  6  slot id
- issued_en  in  1  arbiter's choice issued this cycle
- issued_wf_id  in  6  slot id issued
- retire_en  in  1  in-flight instruction of retire_wf_id completed
- retire_wf_id  in  6  slot id
- retire_is_end  in  1  retiring instruction was s_endpgm
- wf_ready_arry  out  40  bit i = slot i READY; feeds arbiter input vector
- wf_done_en  out  1  one-cycle pulse: wavefront finished
- wf_done_id  out  6  finished slot id
- active_count  out  6  number of non-FREE slots, 0..40
- protocol_err  out  1  sticky illegal-event flag

## Operation
- Per-slot 2-bit FSM: FREE, WAIT_INSTR, READY, INFLIGHT.
- FREE + dispatch -> WAIT_INSTR.
- WAIT_INSTR + instr_valid -> READY.
- READY + issued -> INFLIGHT.
- INFLIGHT + retire, retire_is_end=1 -> FREE, wf_done pulse.
- INFLIGHT + retire, retire_is_end=0 -> WAIT_INSTR; if instr_valid for same slot in same cycle -> READY directly.
- Any other event/state pair (dispatch to non-FREE, issue of non-READY, instr_valid outside WAIT_INSTR/retiring-INFLIGHT, retire of non-INFLIGHT): slot state unchanged, protocol_err set.
- Any id >= 40 on an asserted event: ignored, protocol_err set.
- Events on distinct slots in the same cycle are all applied independently.
- wf_ready_arry[i] = (state_i == READY), decoded directly from state flops (no extra register).
- active_count = population count of non-FREE slots, registered, updated every cycle.
- protocol_err cleared only by rst.

## Timing
- Reset: all slots FREE; wf_ready_arry=0, wf_done_en=0, wf_done_id=0, active_count=0, protocol_err=0.
- instr_valid at edge N -> ready bit high after edge N (visible cycle N+1).
- issued_en at edge N -> ready bit low from cycle N+1; arbiter never sees a stale bit for the issued slot past one cycle.
- retire end at edge N -> wf_done_en high for exactly cycle N+1 with wf_done_id; slot FREE and active_count decremented in cycle N+1.
- Dispatch at edge N -> active_count incremented in cycle N+1.
- Simultaneous dispatch of slot A and end-retire of slot B: count unchanged.
- Two end-retires cannot occur in one cycle (single retire port).
- rst asserted mid-operation: all state cleared immediately, no wf_done pulse.

## Structure
- Shared package: NUM_WF, WF_ID_W, slot state encodings (FREE=0, WAIT_INSTR=1, READY=2, INFLIGHT=3).
- Sub-module wf_slot_fsm: one slot's FSM with per-slot hit lines (dispatch/instr/issue/retire/end) and illegal-event output; instantiated NUM_WF times by generate.
- Top: id-to-one-hot decode of four event ports (range-checked), error OR-reduce, popcount, done pulse register.

## Test plan
- Reset, dispatch slot 5, instr_valid 5 -> wf_ready_arry = 1<<5 next cycle, active_count=1.
- Slot 5 READY, issued_en id 5 -> bit 5 low next cycle; retire 5 not end with instr_valid 5 same cycle -> bit 5 high next cycle.
- Retire slot 5 with retire_is_end -> wf_done_en one cycle, wf_done_id=5, active_count=0.
- Fill all 40 slots -> active_count=40; dispatch id 12 again -> protocol_err=1, count stays 40.
- issued_en with id 45 -> protocol_err=1, wf_ready_arry unchanged.
- Slots 0 and 39 READY, assert rst asynchronously mid-cycle -> wf_ready_arry=0, active_count=0 immediately, no wf_done pulse.
